// File: rtl/recv_module.sv
// Receive-side endpoint for one switch output port: parses header beats, checks the
// payload pattern, drives ready and reports per-packet status, errors and counters.
//
// state   | meaning
// IDLE    | waiting for a header beat
// PAYLOAD | accepting payload beats of a parsed packet, cnt = beat index
// DROP    | swallowing beats of a bad packet until its eop

module recv_module #(
  parameter int RX_PORT         = 0,
  parameter int PORT_NUB_TOTAL  = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_LENGTH_MAX = 128,
  parameter int PRIORITY        = 8,
  parameter int WIDTH_SEL       = $clog2(PORT_NUB_TOTAL),
  parameter int WIDTH_LENGTH    = $clog2(DATA_LENGTH_MAX),
  parameter int WIDTH_PRIORITY  = $clog2(PRIORITY)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd_sop,
  input  logic                      rd_eop,
  input  logic                      rd_vld,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  input  logic                      ready_en,
  output logic                      ready,
  output logic                      pkt_done,
  output logic [WIDTH_SEL-1:0]      pkt_src,
  output logic [WIDTH_PRIORITY-1:0] pkt_pri,
  output logic [WIDTH_LENGTH-1:0]   pkt_len,
  output logic                      err_vld,
  output logic [2:0]                err_code,
  output logic [15:0]               pkt_cnt,
  output logic [15:0]               err_cnt
);

  localparam int POS_PRI = WIDTH_SEL;
  localparam int POS_LEN = POS_PRI + WIDTH_PRIORITY;
  localparam int POS_TAG = POS_LEN + WIDTH_LENGTH;
  localparam logic [WIDTH_SEL-1:0] RX_SEL = WIDTH_SEL'(RX_PORT);

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_DEST   = 3'd1;
  localparam logic [2:0] ERR_LEN    = 3'd2;
  localparam logic [2:0] ERR_DATA   = 3'd3;
  localparam logic [2:0] ERR_SOP    = 3'd4;
  localparam logic [2:0] ERR_ORPHAN = 3'd5;
  localparam logic [2:0] ERR_OVF    = 3'd6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } state_t;

  state_t                    state, state_nxt, hdr_state;
  logic [WIDTH_LENGTH-1:0]   cnt, cnt_nxt;
  logic [WIDTH_SEL-1:0]      cur_src, src_nxt;
  logic [WIDTH_PRIORITY-1:0] cur_pri, pri_nxt;
  logic [WIDTH_LENGTH-1:0]   cur_len, len_nxt;
  logic                      done_nxt;
  logic [2:0]                err_nxt, hdr_err;

  logic [WIDTH_SEL-1:0]      hdr_dest, hdr_src;
  logic [WIDTH_PRIORITY-1:0] hdr_pri;
  logic [WIDTH_LENGTH-1:0]   hdr_len;
  logic                      dest_bad;
  logic                      last_beat;
  logic [DATA_WIDTH-1:0]     exp_data;

  assign hdr_dest  = rd_data[WIDTH_SEL-1:0];
  assign hdr_pri   = rd_data[POS_PRI +: WIDTH_PRIORITY];
  assign hdr_len   = rd_data[POS_LEN +: WIDTH_LENGTH];
  assign hdr_src   = rd_data[POS_TAG +: WIDTH_SEL];
  assign dest_bad  = (hdr_dest != RX_SEL);
  assign last_beat = (cnt == (cur_len - WIDTH_LENGTH'(1)));

  always_comb begin
    exp_data = '0;
    exp_data[DATA_WIDTH-1 -: WIDTH_SEL] = cur_src;
    exp_data[15:0] = 16'(cnt);
  end

  // Outcome of a header beat, independent of whether it also aborts a packet.
  always_comb begin
    hdr_state = PAYLOAD;
    hdr_err   = ERR_NONE;
    if (rd_eop) begin
      hdr_state = IDLE;
      hdr_err   = dest_bad ? ERR_DEST : ERR_LEN;
    end else if (dest_bad) begin
      hdr_state = DROP;
      hdr_err   = ERR_DEST;
    end else if (hdr_len == '0) begin
      hdr_state = DROP;
      hdr_err   = ERR_LEN;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    src_nxt   = cur_src;
    pri_nxt   = cur_pri;
    len_nxt   = cur_len;
    done_nxt  = 1'b0;
    err_nxt   = ERR_NONE;
    if (rd_vld) begin
      if (rd_sop) begin
        state_nxt = hdr_state;
        cnt_nxt   = '0;
        src_nxt   = hdr_src;
        pri_nxt   = hdr_pri;
        len_nxt   = hdr_len;
        err_nxt   = (state == IDLE) ? hdr_err : ERR_SOP;
      end else begin
        case (state)
          IDLE: err_nxt = ERR_ORPHAN;
          PAYLOAD: begin
            if (rd_eop && !last_beat) begin
              state_nxt = IDLE;
              err_nxt   = ERR_LEN;
            end else if (!rd_eop && last_beat) begin
              state_nxt = DROP;
              err_nxt   = ERR_LEN;
            end else if (rd_data != exp_data) begin
              state_nxt = rd_eop ? IDLE : DROP;
              err_nxt   = ERR_DATA;
            end else if (rd_eop) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt + WIDTH_LENGTH'(1);
            end
          end
          DROP: if (rd_eop) state_nxt = IDLE;
          default: state_nxt = IDLE;
        endcase
      end
      // Overflow outranks everything else but the beat is still processed above.
      if (!ready) err_nxt = ERR_OVF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_src <= '0;
      cur_pri <= '0;
      cur_len <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cur_src <= src_nxt;
      cur_pri <= pri_nxt;
      cur_len <= len_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready    <= 1'b0;
      pkt_done <= 1'b0;
      pkt_src  <= '0;
      pkt_pri  <= '0;
      pkt_len  <= '0;
      err_vld  <= 1'b0;
      err_code <= ERR_NONE;
      pkt_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      ready    <= ready_en;
      pkt_done <= done_nxt;
      err_vld  <= (err_nxt != ERR_NONE);
      err_code <= err_nxt;
      if (done_nxt) begin
        pkt_src <= cur_src;
        pkt_pri <= cur_pri;
        pkt_len <= cur_len;
        if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
      end
      if (err_nxt != ERR_NONE && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule
